// File: rtl/glitc_intercom_ctrl_multi_pkg.sv
// Shared definitions for the N-path GLITC intercom control bank: register offsets,
// bit positions, echo sequencer state encoding and statistics layout.
package glitc_intercom_pkg;

    localparam logic [1:0] REG_CTRL0   = 2'd0;
    localparam logic [1:0] REG_CTRL1   = 2'd1;
    localparam logic [1:0] REG_TRAIN   = 2'd2;
    localparam logic [1:0] REG_ECHOSEQ = 2'd3;

    localparam int CTRL0_ISERDES_RST = 0;
    localparam int CTRL0_OSERDES_RST = 1;
    localparam int CTRL0_IBUFDS_DIS  = 2;
    localparam int CTRL0_OSERDES_CE  = 3;

    localparam int CTRL1_ENABLE      = 0;
    localparam int CTRL1_TRAIN_DONE  = 1;
    localparam int CTRL1_TRAIN       = 2;
    localparam int CTRL1_SEND_SYNC   = 3;
    localparam int CTRL1_SYNC_RCVD   = 4;
    localparam int CTRL1_RESYNCED    = 5;
    localparam int CTRL1_SEND_ECHO   = 6;
    localparam int CTRL1_ECHO_SEEN   = 7;
    localparam int CTRL1_LAT_LSB     = 8;
    localparam int CTRL1_STATUS_RST  = 31;

    localparam int TRAIN_CHK_LSB     = 20;
    localparam int ECHOSEQ_DONE      = 30;
    localparam int ECHOSEQ_BUSY      = 31;

    localparam int STAT_W = 8;
    localparam int FAIL_W = 4;
    localparam int CHK_W  = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Packed so it drops straight into ECHOSEQ[27:0].
    typedef struct packed {
        logic [FAIL_W-1:0] failures;
        logic [STAT_W-1:0] lat_max;
        logic [STAT_W-1:0] lat_min;
        logic [STAT_W-1:0] successes;
    } echo_stats_t;

    localparam echo_stats_t ECHO_STATS_RESET = '{
        failures:  '0,
        lat_max:   '0,
        lat_min:   8'hFF,
        successes: '0
    };

    function automatic logic [FAIL_W-1:0] sat_inc_fail(input logic [FAIL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/glitc_intercom_ctrl_multi_if.sv
// User register bus of the intercom control bank: write strobe, select, address, data in/out.
interface glitc_intercom_ctrl_multi_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  wr;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wr_dat;
    logic [31:0]           rd_dat;

    modport master (output wr, sel, addr, wr_dat, input rd_dat);
    modport slave  (input wr, sel, addr, wr_dat, output rd_dat);
endinterface

// File: rtl/glitc_intercom_ctrl_multi_echo_seq.sv
// Per-path automatic echo sequencer: issues N echoes, times out missing replies,
// and keeps success/failure counts with min/max latency.
module glitc_intercom_echo_seq
    import glitc_intercom_pkg::*;
#(
    parameter int LATENCY_WIDTH = 4,
    parameter int ECHO_TIMEOUT  = 255,
    parameter int ECHO_GAP      = 16
) (
    input  logic                     user_clk_i,
    input  logic                     user_rst_i,
    input  logic                     start,
    input  logic                     abort,
    input  logic [7:0]               count,
    input  logic                     echo_ready,
    input  logic                     echo_seen,
    input  logic [LATENCY_WIDTH-1:0] latency,
    output logic                     echo_pulse,
    output logic                     busy,
    output logic                     done,
    output echo_stats_t              stats
);
    localparam int TIMER_W = 16;
    localparam int GAP_W   = 8;

    logic [1:0]         state;
    logic [7:0]         remaining;
    logic [7:0]         remaining_dec;
    logic [TIMER_W-1:0] timer;
    logic [GAP_W-1:0]   gap_cnt;
    logic [STAT_W-1:0]  lat_ext;
    logic               timed_out;

    assign lat_ext       = STAT_W'(latency);
    assign remaining_dec = remaining - 8'd1;
    assign timed_out     = (timer == TIMER_W'(ECHO_TIMEOUT - 1));
    assign echo_pulse    = (state == ST_SEND);
    assign busy          = (state != ST_IDLE);

    // NOTE: every register here uses <= so all branches read the pre-edge state;
    // a blocking = would let later branches see half-updated values.
    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            state     <= ST_IDLE;
            remaining <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            done      <= 1'b0;
            stats     <= ECHO_STATS_RESET;
        end else if (abort && busy) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        stats     <= ECHO_STATS_RESET;
                        done      <= 1'b0;
                        remaining <= count;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A reply landing on the timeout cycle still counts as a reply.
                    if (echo_ready) begin
                        if (echo_seen) begin
                            stats.successes <= stats.successes + 1'b1;
                            if (lat_ext < stats.lat_min) stats.lat_min <= lat_ext;
                            if (lat_ext > stats.lat_max) stats.lat_max <= lat_ext;
                        end else begin
                            stats.failures <= sat_inc_fail(stats.failures);
                        end
                    end else if (timed_out) begin
                        stats.failures <= sat_inc_fail(stats.failures);
                    end else begin
                        timer <= timer + 1'b1;
                    end

                    if (echo_ready || timed_out) begin
                        remaining <= remaining_dec;
                        gap_cnt   <= '0;
                        if (ECHO_GAP != 0) begin
                            state <= ST_GAP;
                        end else if (remaining_dec == '0) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SEND;
                        end
                    end
                end
                default: begin
                    if (gap_cnt == GAP_W'(ECHO_GAP - 1)) begin
                        if (remaining == '0) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SEND;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/glitc_intercom_ctrl_multi.sv
// N-path GLITC intercom control register bank with sticky status and echo sequencers.
// Optional training-word checker enabled by defining GLITC_INTERCOM_TRAIN_CHECK_EN.
module glitc_intercom_ctrl_multi
    import glitc_intercom_pkg::*;
#(
    parameter int          NPATH         = 2,
    parameter int          ADDR_WIDTH    = 5,
    parameter int          LATENCY_WIDTH = 4,
    parameter int          TRAIN_WIDTH   = 20,
    parameter int          ECHO_TIMEOUT  = 255,
    parameter int          ECHO_GAP      = 16,
    parameter logic [19:0] TRAIN_PATTERN = 20'hA5C3F
) (
    input  logic                             user_clk_i,
    input  logic                             user_rst_i,
    glitc_intercom_ctrl_multi_if.slave       user_bus,
    output logic [NPATH-1:0]                 iserdes_reset_o,
    output logic [NPATH-1:0]                 oserdes_reset_o,
    output logic [NPATH-1:0]                 ibufds_disable_o,
    output logic [NPATH-1:0]                 oserdes_ce_o,
    output logic [NPATH-1:0]                 status_reset_o,
    output logic [NPATH-1:0]                 send_sync_o,
    output logic [NPATH-1:0]                 send_echo_o,
    input  logic [NPATH-1:0]                 sync_received_i,
    input  logic [NPATH-1:0]                 resynced_i,
    input  logic [NPATH-1:0]                 echo_ready_i,
    input  logic [NPATH-1:0]                 echo_seen_i,
    input  logic [NPATH*LATENCY_WIDTH-1:0]   latency_i,
    output logic [NPATH-1:0]                 enable_o,
    output logic [NPATH-1:0]                 train_o,
    output logic [NPATH-1:0]                 training_done_o,
    input  logic [NPATH-1:0]                 train_latch_i,
    output logic [NPATH-1:0]                 train_latch_seen_o,
    input  logic [NPATH*TRAIN_WIDTH-1:0]     train_i
);
    localparam int PATH_W = ADDR_WIDTH - 2;

    logic [PATH_W-1:0] bus_path;
    logic [1:0]        bus_reg;
    logic              bus_wr;
    logic [31:0]       wdat;
    logic [31:0]       path_rdata [NPATH];
    logic              unused_wdat;

    assign bus_path    = user_bus.addr[ADDR_WIDTH-1:2];
    assign bus_reg     = user_bus.addr[1:0];
    assign bus_wr      = user_bus.sel && user_bus.wr;
    assign wdat        = user_bus.wr_dat;
    assign unused_wdat = ^wdat[30:8];

    for (genvar p = 0; p < NPATH; p++) begin : g_path
        logic hit, wr_ctrl0, wr_ctrl1, wr_seq, status_clr;
        logic iserdes_rst_q, oserdes_rst_q, ibufds_dis_q, oserdes_ce_q;
        logic enable_q, train_done_q, train_q, send_sync_q, status_rst_q, manual_echo_q;
        logic sync_sticky, resync_sticky, last_seen, latch_seen_q;
        logic [LATENCY_WIDTH-1:0] lat_in, last_lat;
        logic [TRAIN_WIDTH-1:0]   train_in, train_word;
        logic [CHK_W-1:0]         chk_cnt;
        logic                     seq_pulse, seq_busy, seq_done;
        echo_stats_t              seq_stats;
        logic [31:0]              rd;

        assign hit        = bus_wr && (bus_path == PATH_W'(p));
        assign wr_ctrl0   = hit && (bus_reg == REG_CTRL0);
        assign wr_ctrl1   = hit && (bus_reg == REG_CTRL1);
        assign wr_seq     = hit && (bus_reg == REG_ECHOSEQ);
        assign status_clr = wr_ctrl1 && wdat[CTRL1_STATUS_RST];
        assign lat_in     = latency_i[p*LATENCY_WIDTH +: LATENCY_WIDTH];
        assign train_in   = train_i[p*TRAIN_WIDTH +: TRAIN_WIDTH];

        always_ff @(posedge user_clk_i) begin
            if (user_rst_i) begin
                iserdes_rst_q <= 1'b0;
                oserdes_rst_q <= 1'b0;
                ibufds_dis_q  <= 1'b1;
                oserdes_ce_q  <= 1'b0;
                enable_q      <= 1'b0;
                train_done_q  <= 1'b0;
                train_q       <= 1'b0;
                send_sync_q   <= 1'b0;
                status_rst_q  <= 1'b0;
                manual_echo_q <= 1'b0;
                sync_sticky   <= 1'b0;
                resync_sticky <= 1'b0;
                last_seen     <= 1'b0;
                last_lat      <= '0;
                train_word    <= '0;
                latch_seen_q  <= 1'b0;
            end else begin
                iserdes_rst_q <= wr_ctrl0 && wdat[CTRL0_ISERDES_RST];
                oserdes_rst_q <= wr_ctrl0 && wdat[CTRL0_OSERDES_RST];
                if (wr_ctrl0) begin
                    ibufds_dis_q <= wdat[CTRL0_IBUFDS_DIS];
                    oserdes_ce_q <= wdat[CTRL0_OSERDES_CE];
                end
                if (wr_ctrl1) begin
                    enable_q     <= wdat[CTRL1_ENABLE];
                    train_done_q <= wdat[CTRL1_TRAIN_DONE];
                    train_q      <= wdat[CTRL1_TRAIN];
                end
                send_sync_q   <= wr_ctrl1 && wdat[CTRL1_SEND_SYNC];
                status_rst_q  <= status_clr;
                manual_echo_q <= wr_ctrl1 && wdat[CTRL1_SEND_ECHO] && !seq_busy;

                // Set has priority so an event coinciding with the clear is not lost.
                if (sync_received_i[p])  sync_sticky <= 1'b1;
                else if (status_clr)     sync_sticky <= 1'b0;
                if (resynced_i[p])       resync_sticky <= 1'b1;
                else if (status_clr)     resync_sticky <= 1'b0;

                if (echo_ready_i[p]) begin
                    last_seen <= echo_seen_i[p];
                    last_lat  <= lat_in;
                end
                if (train_latch_i[p]) train_word <= train_in;
                latch_seen_q <= train_latch_i[p];
            end
        end

`ifdef GLITC_INTERCOM_TRAIN_CHECK_EN
        always_ff @(posedge user_clk_i) begin
            if (user_rst_i) begin
                chk_cnt <= '0;
            end else if (train_latch_i[p] && (train_in != TRAIN_PATTERN[TRAIN_WIDTH-1:0])) begin
                if (chk_cnt != '1) chk_cnt <= chk_cnt + 1'b1;
            end else if (status_clr) begin
                chk_cnt <= '0;
            end
        end
`else
        logic unused_pattern;
        assign unused_pattern = ^TRAIN_PATTERN;
        assign chk_cnt        = '0;
`endif

        glitc_intercom_echo_seq #(
            .LATENCY_WIDTH (LATENCY_WIDTH),
            .ECHO_TIMEOUT  (ECHO_TIMEOUT),
            .ECHO_GAP      (ECHO_GAP)
        ) u_echo_seq (
            .user_clk_i (user_clk_i),
            .user_rst_i (user_rst_i),
            .start      (wr_seq && (wdat[7:0] != 8'd0)),
            .abort      (wr_seq && (wdat[7:0] == 8'd0)),
            .count      (wdat[7:0]),
            .echo_ready (echo_ready_i[p]),
            .echo_seen  (echo_seen_i[p]),
            .latency    (lat_in),
            .echo_pulse (seq_pulse),
            .busy       (seq_busy),
            .done       (seq_done),
            .stats      (seq_stats)
        );

        // NOTE: rd is cleared first so every case arm leaves the unlisted bits
        // defined; without that default the block would infer latches.
        always_comb begin
            rd = '0;
            case (bus_reg)
                REG_CTRL0: begin
                    rd[CTRL0_IBUFDS_DIS] = ibufds_dis_q;
                    rd[CTRL0_OSERDES_CE] = oserdes_ce_q;
                end
                REG_CTRL1: begin
                    rd[CTRL1_ENABLE]             = enable_q;
                    rd[CTRL1_TRAIN_DONE]         = train_done_q;
                    rd[CTRL1_TRAIN]              = train_q;
                    rd[CTRL1_SYNC_RCVD]          = sync_sticky;
                    rd[CTRL1_RESYNCED]           = resync_sticky;
                    rd[CTRL1_ECHO_SEEN]          = last_seen;
                    rd[CTRL1_LAT_LSB +: STAT_W]  = STAT_W'(last_lat);
                end
                REG_TRAIN: begin
                    rd[TRAIN_WIDTH-1:0]          = train_word;
                    rd[TRAIN_CHK_LSB +: CHK_W]   = chk_cnt;
                end
                default: begin
                    rd[$bits(echo_stats_t)-1:0]  = seq_stats;
                    rd[ECHOSEQ_DONE]             = seq_done;
                    rd[ECHOSEQ_BUSY]             = seq_busy;
                end
            endcase
        end

        assign path_rdata[p]         = rd;
        assign iserdes_reset_o[p]    = iserdes_rst_q;
        assign oserdes_reset_o[p]    = oserdes_rst_q;
        assign ibufds_disable_o[p]   = ibufds_dis_q;
        assign oserdes_ce_o[p]       = oserdes_ce_q;
        assign status_reset_o[p]     = status_rst_q;
        assign send_sync_o[p]        = send_sync_q;
        assign send_echo_o[p]        = manual_echo_q || seq_pulse;
        assign enable_o[p]           = enable_q;
        assign train_o[p]            = train_q;
        assign training_done_o[p]    = train_done_q;
        assign train_latch_seen_o[p] = latch_seen_q;
    end

    // Paths at or above NPATH fall through to zero.
    always_comb begin
        user_bus.rd_dat = '0;
        for (int p = 0; p < NPATH; p++) begin
            if (int'(bus_path) == p) user_bus.rd_dat = path_rdata[p];
        end
    end

endmodule

// File: tb/tb_glitc_intercom_ctrl_multi.sv
// Directed bench for glitc_intercom_ctrl_multi; expected TRAIN checker count follows
// GLITC_INTERCOM_TRAIN_CHECK_EN.
module tb_glitc_intercom_ctrl_multi;
    localparam int NPATH = 2;
    localparam int AW    = 5;
    localparam int LW    = 4;
    localparam int TW    = 20;
    localparam int TO    = 12;
    localparam int GAP   = 4;

    logic user_clk_i = 1'b0;
    logic user_rst_i;
    logic [NPATH-1:0] iserdes_reset_o, oserdes_reset_o, ibufds_disable_o, oserdes_ce_o;
    logic [NPATH-1:0] status_reset_o, send_sync_o, send_echo_o;
    logic [NPATH-1:0] sync_received_i, resynced_i, echo_ready_i, echo_seen_i;
    logic [NPATH*LW-1:0] latency_i;
    logic [NPATH-1:0] enable_o, train_o, training_done_o, train_latch_i, train_latch_seen_o;
    logic [NPATH*TW-1:0] train_i;

    glitc_intercom_ctrl_multi_if #(.ADDR_WIDTH(AW)) bus ();

    glitc_intercom_ctrl_multi #(
        .NPATH(NPATH), .ADDR_WIDTH(AW), .LATENCY_WIDTH(LW), .TRAIN_WIDTH(TW),
        .ECHO_TIMEOUT(TO), .ECHO_GAP(GAP), .TRAIN_PATTERN(20'hA5C3F)
    ) dut (
        .user_clk_i         (user_clk_i),
        .user_rst_i         (user_rst_i),
        .user_bus           (bus),
        .iserdes_reset_o    (iserdes_reset_o),
        .oserdes_reset_o    (oserdes_reset_o),
        .ibufds_disable_o   (ibufds_disable_o),
        .oserdes_ce_o       (oserdes_ce_o),
        .status_reset_o     (status_reset_o),
        .send_sync_o        (send_sync_o),
        .send_echo_o        (send_echo_o),
        .sync_received_i    (sync_received_i),
        .resynced_i         (resynced_i),
        .echo_ready_i       (echo_ready_i),
        .echo_seen_i        (echo_seen_i),
        .latency_i          (latency_i),
        .enable_o           (enable_o),
        .train_o            (train_o),
        .training_done_o    (training_done_o),
        .train_latch_i      (train_latch_i),
        .train_latch_seen_o (train_latch_seen_o),
        .train_i            (train_i)
    );

    always #5 user_clk_i = ~user_clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Echo pulse monitor for path 0, sampled on the falling edge.
    int cyc = 0;
    int echo0_cnt = 0;
    int echo0_last = -1;
    int echo0_min_gap = 1000;
    always @(negedge user_clk_i) begin
        cyc++;
        if (send_echo_o[0]) begin
            if (echo0_last >= 0 && (cyc - echo0_last) < echo0_min_gap) echo0_min_gap = cyc - echo0_last;
            echo0_last = cyc;
            echo0_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge user_clk_i);
            #1;
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] addr, input logic [31:0] data);
        bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = addr; bus.wr_dat = data;
        tick();
        bus.sel = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = addr;
        #1;
        d = bus.rd_dat;
        bus.sel = 1'b0;
        check(tag, d, exp);
    endtask

    task automatic wait_echo(input int p, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (send_echo_o[p]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(input logic [AW-1:0] addr, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = addr;
            #1;
            bus.sel = 1'b0;
            if (bus.rd_dat[30]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic respond(input int p, input logic [LW-1:0] lat, input logic seen);
        echo_ready_i[p] = 1'b1;
        echo_seen_i[p]  = seen;
        latency_i[p*LW +: LW] = lat;
        tick();
        echo_ready_i[p] = 1'b0;
        echo_seen_i[p]  = 1'b0;
    endtask

    task automatic latch_word(input logic [TW-1:0] w);
        train_i[TW-1:0]  = w;
        train_latch_i[0] = 1'b1;
        tick();
        train_latch_i[0] = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int exp_chk;
        bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wr_dat = '0;
        sync_received_i = '0; resynced_i = '0; echo_ready_i = '0; echo_seen_i = '0;
        latency_i = '0; train_latch_i = '0; train_i = '0;
        user_rst_i = 1'b1;
        tick(3);
        user_rst_i = 1'b0;

        // 1: reset values and CTRL0 behaviour
        check("t1_ibufds_rst", ibufds_disable_o, 32'h3);
        check("t1_ce_rst", oserdes_ce_o, 32'h0);
        check("t1_enable_rst", enable_o, 32'h0);
        check_rd("t1_ctrl0_p0", 5'd0, 32'h4);
        check_rd("t1_ctrl0_p1", 5'd4, 32'h4);
        check_rd("t1_ctrl1_p0", 5'd1, 32'h0);
        check_rd("t1_train_p0", 5'd2, 32'h0);
        check_rd("t1_seq_p0", 5'd3, 32'h0000FF00);
        check_rd("t1_seq_p1", 5'd7, 32'h0000FF00);
        check_rd("t1_oob_ctrl0", 5'd8, 32'h0);
        bus_write(5'd0, 32'h000F000F);
        check("t1_iserdes_pulse", iserdes_reset_o, 32'h1);
        check("t1_oserdes_pulse", oserdes_reset_o, 32'h1);
        check("t1_ibufds", ibufds_disable_o, 32'h3);
        check("t1_ce", oserdes_ce_o, 32'h1);
        tick();
        check("t1_iserdes_end", iserdes_reset_o, 32'h0);
        check("t1_oserdes_end", oserdes_reset_o, 32'h0);
        check_rd("t1_ctrl0_rd", 5'd0, 32'hC);
        bus_write(5'd8, 32'h0000000F);
        check("t1_oob_no_pulse", iserdes_reset_o, 32'h0);
        check_rd("t1_oob_rd", 5'd8, 32'h0);

        // 2: sticky status vs status reset
        sync_received_i[1] = 1'b1;
        bus_write(5'd5, 32'h80000000);
        sync_received_i[1] = 1'b0;
        check("t2_status_pulse", status_reset_o, 32'h2);
        tick();
        check("t2_status_end", status_reset_o, 32'h0);
        check_rd("t2_sticky_kept", 5'd5, 32'h10);
        bus_write(5'd5, 32'h80000000);
        check_rd("t2_sticky_clr", 5'd5, 32'h0);
        resynced_i[1] = 1'b1;
        tick();
        resynced_i[1] = 1'b0;
        bus_write(5'd5, 32'h7);
        check("t2_enable", enable_o, 32'h2);
        check("t2_train", train_o, 32'h2);
        check("t2_train_done", training_done_o, 32'h2);
        check_rd("t2_ctrl1_rd", 5'd5, 32'h27);
        bus_write(5'd5, 32'h8);
        check("t2_sync_pulse", send_sync_o, 32'h2);

        // 3: three sequenced echoes: 5, 9, then timeout
        bus_write(5'd3, 32'd3);
        wait_echo(0, ok); check("t3_echo1", ok, 1);
        tick(); respond(0, 4'd5, 1'b1);
        wait_echo(0, ok); check("t3_echo2", ok, 1);
        tick(); respond(0, 4'd9, 1'b1);
        wait_echo(0, ok); check("t3_echo3", ok, 1);
        wait_done(5'd3, ok); check("t3_done_seen", ok, 1);
        check_rd("t3_seq", 5'd3, 32'h41090502);
        check("t3_pulses", echo0_cnt, 32'd3);
        check("t3_spacing", echo0_min_gap >= GAP, 1);
        check_rd("t3_last", 5'd1, 32'h0980);

        // 4: abort after second echo; manual echo ignored while busy
        bus_write(5'd3, 32'd200);
        wait_echo(0, ok); check("t4_echo1", ok, 1);
        tick(); respond(0, 4'd7, 1'b1);
        wait_echo(0, ok); check("t4_echo2", ok, 1);
        bus_write(5'd1, 32'h40);
        check("t4_manual_busy", send_echo_o[0], 0);
        bus_write(5'd3, 32'd0);
        tick(40);
        check("t4_no_more", echo0_cnt, 32'd5);
        check_rd("t4_seq", 5'd3, 32'h00070701);
        bus_write(5'd1, 32'h40);
        check("t4_manual_idle", send_echo_o[0], 1);
        tick();
        check("t4_manual_end", send_echo_o[0], 0);

        // 5: reply exactly on the timeout cycle, then reset mid-wait
        bus_write(5'd7, 32'd1);
        wait_echo(1, ok); check("t5_echo", ok, 1);
        tick();
        tick(TO - 1);
        respond(1, 4'd3, 1'b1);
        wait_done(5'd7, ok); check("t5_done_seen", ok, 1);
        check_rd("t5_seq", 5'd7, 32'h40030301);
        bus_write(5'd7, 32'd5);
        wait_echo(1, ok); check("t5_echo_rst", ok, 1);
        tick();
        user_rst_i = 1'b1;
        tick();
        user_rst_i = 1'b0;
        check_rd("t5_seq_rst", 5'd7, 32'h0000FF00);
        check_rd("t5_ctrl1_rst", 5'd5, 32'h0);
        check("t5_ce_rst", oserdes_ce_o, 32'h0);
        check("t5_ibufds_rst", ibufds_disable_o, 32'h3);
        tick(30);
        check("t5_no_echo", send_echo_o, 32'h0);

        // 6: training word capture and optional checker
`ifdef GLITC_INTERCOM_TRAIN_CHECK_EN
        exp_chk = 2;
`else
        exp_chk = 0;
`endif
        train_i[TW-1:0]  = 20'hA5C3F;
        train_latch_i[0] = 1'b1;
        tick();
        train_latch_i[0] = 1'b0;
        check("t6_seen_hi", train_latch_seen_o, 32'h1);
        tick();
        check("t6_seen_lo", train_latch_seen_o, 32'h0);
        latch_word(20'h11111);
        latch_word(20'hA5C3F);
        latch_word(20'hA5C3F);
        latch_word(20'h12345);
        check_rd("t6_train", 5'd2, (32'(exp_chk) << 20) | 32'h12345);
        bus_write(5'd1, 32'h80000000);
        check_rd("t6_train_clr", 5'd2, 32'h12345);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/glitc_intercom_ctrl_multi.md
Name: glitc_intercom_ctrl_multi

Overview:
Parametrised, N-path successor to the two-path GLITC intercom control register bank. It sits on the user register bus and drives the per-path SERDES, training, sync and echo controls of the intercom links. It adds sticky status bits, an optional training-word checker, and a per-path automatic echo sequencer. The sequencer issues a programmed number of echoes, handles timeouts, and accumulates min/max latency statistics.

Parameters:
- NPATH, 2, number of intercom paths (1..8).
- ADDR_WIDTH, 5, user address width; requires NPATH <= 2^(ADDR_WIDTH-2).
- LATENCY_WIDTH, 4, echo latency width (1..8).
- TRAIN_WIDTH, 20, training word width per path (1..20).
- ECHO_TIMEOUT, 255, cycles to wait for echo_ready before declaring a failure (1..65535).
- ECHO_GAP, 16, idle cycles between sequenced echoes (0..255).
- TRAIN_PATTERN, 20'hA5C3F, expected training word (used only with the optional feature).

Ports:
- user_clk_i  in  1  single clock for all logic.
- user_rst_i  in  1  synchronous, active-high reset.
- user_wr_i  in  1  write strobe.
- user_sel_i  in  1  block select.
- user_addr_i  in  ADDR_WIDTH  {path, reg[1:0]}.
- user_dat_i  in  32  write data.
- user_dat_o  out  32  combinational read data.
- iserdes_reset_o, oserdes_reset_o  out  NPATH  one-cycle reset pulses.
- ibufds_disable_o, oserdes_ce_o  out  NPATH  level controls.
- status_reset_o, send_sync_o, send_echo_o  out  NPATH  one-cycle pulses.
- sync_received_i, resynced_i, echo_ready_i, echo_seen_i  in  NPATH  link status.
- latency_i  in  NPATH*LATENCY_WIDTH  echo latency, valid with echo_ready_i.
- enable_o, train_o, training_done_o  out  NPATH  level controls.
- train_latch_i  in  NPATH  training word valid.
- train_latch_seen_o  out  NPATH  train_latch_i delayed one cycle.
- train_i  in  NPATH*TRAIN_WIDTH  training words.

Behaviour:

Register map (per path p):
- Path p occupies addresses p*4+0..3.
- Path index >= NPATH: reads 0, writes ignored.
- +0 CTRL0:
  - [0] iserdes reset pulse.
  - [1] oserdes reset pulse.
  - [2] ibufds disable (reset 1).
  - [3] oserdes ce.
  - Reads return [3:2] only.
- +1 CTRL1:
  - [0] enable.
  - [1] training done.
  - [2] train mode.
  - [3] send sync pulse.
  - [4] sync_received (sticky, RO).
  - [5] resynced (sticky, RO).
  - [6] manual send echo pulse.
  - [7] last echo_seen (RO).
  - [15:8] last latency, zero-extended (RO).
  - [31] status reset pulse.
- +2 TRAIN:
  - [TRAIN_WIDTH-1:0] last latched training word.
  - [31:20] checker count (see Optional Feature).
- +3 ECHOSEQ:
  - Write: [7:0] echo count N; N=0 aborts.
  - Read: [7:0] successes, [15:8] min latency, [23:16] max latency, [27:24] failures (saturating at 15), [30] done, [31] busy.

Register and pulse rules:
- Registered outputs update on the cycle after the write.
- Pulses are high for exactly one cycle.
- Reset values: all outputs 0 except ibufds_disable_o = all ones. Min latency resets to 0xFF; all other stats reset to 0.
- Sticky bits set on input high and clear on status reset. Set wins if both occur in the same cycle.
- Status reset does not clear echo statistics.
- train_latch_i: training word captured the same cycle; train_latch_seen_o is high one cycle later.

Echo sequencer, one per path:
- IDLE: write N>0 -> clear stats, done=0, remaining=N -> SEND.
- SEND: one-cycle internal echo pulse -> WAIT, timer=0.
- WAIT:
  - echo_ready & echo_seen -> update min/max/last, successes++.
  - echo_ready & !echo_seen, or timer == ECHO_TIMEOUT-1 -> failures++.
  - echo_ready wins if it coincides with the timeout cycle.
  - Then remaining-- and -> GAP.
- GAP: ECHO_GAP cycles; then remaining==0 -> IDLE with done=1, else -> SEND.
- While busy: write N=0 -> IDLE, done=0, stats kept; write N>0 is ignored; manual CTRL1[6] is ignored.
- send_echo_o = manual pulse OR sequencer pulse.
- echo_ready while IDLE updates last latency and echo_seen only.
- user_rst_i mid-sequence -> IDLE with reset values.

Optional Feature:
GLITC_INTERCOM_TRAIN_CHECK_EN
- Defined: each train_latch_i compares the training word against TRAIN_PATTERN[TRAIN_WIDTH-1:0]. A mismatch increments a per-path 12-bit counter, saturating at 4095, read at TRAIN[31:20]. The counter clears on status reset or user_rst_i. Increment wins if it coincides with a status reset.
- Undefined: TRAIN[31:20] reads 0; no checker logic is built.

Decomposition:
- Package glitc_intercom_pkg holds:
  - register offsets (CTRL0=0, CTRL1=1, TRAIN=2, ECHOSEQ=3);
  - all bit indices;
  - echo FSM state enum (IDLE, SEND, WAIT, GAP);
  - stat field widths.
- Sub-module glitc_intercom_echo_seq holds one sequencer plus its statistics, instantiated per path in a generate loop.

Test Plan:
1. Reset, then read every register -> CTRL0 = 0x4 per path, ECHOSEQ = 0x0000FF00. Write 0x000F000F to CTRL0 p0 -> iserdes/oserdes reset pulse 1 cycle; ibufds_disable_o[0]=1, oserdes_ce_o[0]=1.
2. Pulse sync_received_i[1] on the same cycle as a CTRL1 p1 write of bit31 -> bit4 remains 1. Next status reset alone -> bit4 = 0.
3. ECHOSEQ p0 write N=3; respond with latencies 5, 9 (echo_seen=1), then no response -> successes 2, min 5, max 9, failures 1, done=1. Exactly 3 send_echo_o[0] pulses, spaced >= ECHO_GAP.
4. Write N=200, abort with N=0 after the 2nd echo -> busy=0, done=0, no further pulses. Manual echo during busy -> no pulse.
5. echo_ready on the exact timeout cycle -> counted as success, not failure. Assert user_rst_i during WAIT -> IDLE with reset values.
6. With GLITC_INTERCOM_TRAIN_CHECK_EN: latch 3 matching and 2 mismatching words -> TRAIN[31:20] = 2. Without the macro -> TRAIN[31:20] = 0.
